booth_mul_sched: RTL and testbench

- Round-robin scheduler sharing one iterative radix-4 Booth significand multiplier core between NREQ requesters, e.g. FP multiply lanes or the divider's reciprocal step.
- Accepts operand pairs over valid/ready, launches the core, counts its fixed latency, captures the product and returns it to the owning requester over valid/ready.
- Only one operation is in flight at a time.

---
 rtl/booth_sched_pkg.sv | 10 +
 rtl/booth_mul_sched_rr_arbiter.sv | 22 ++
 rtl/booth_mul_sched.sv | 80 ++++++++
 tb/tb_booth_mul_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg: shared states, defaults and latency helpers for booth_mul_sched
package booth_sched_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;
  localparam int W_DEF = 12;
  localparam int NREQ_DEF = 2;
  function automatic int lat_of(input int w);
    return w / 2 + 2;
  endfunction
  localparam int CNT_W = $clog2(lat_of(W_DEF));
endpackage

// File: rtl/booth_mul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr modulo N
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  int off;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    off = 0;
    any = |rot;
    for (int k = N - 1; k >= 0; k--) off = rot[k] ? k : off;
    idx = PW'((int'(ptr) + off >= N) ? int'(ptr) + off - N : int'(ptr) + off);
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin sharing of one fixed-latency Booth multiplier core
// Optional BOOTH_ZERO_BYPASS_EN: zero operands answer 0 without launching the core
module booth_mul_sched
  import booth_sched_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = lat_of(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_p,
  output logic              core_start,
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  input  logic [2*W-1:0]    core_p,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LAT);
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif
  state_t state, nxt;
  logic [PW-1:0] rr_ptr, owner, g;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] grant;
  logic [W-1:0] sa, sb;
  logic any, acc, byp;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (.req(req_valid), .ptr(rr_ptr), .grant(grant), .idx(g), .any(any));
  assign sa = req_a[g*W +: W];
  assign sb = req_b[g*W +: W];
  assign acc = (state == IDLE) && !rst && any;
  assign byp = ZB && (~|sa || ~|sb);
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign rsp_valid = (state == RESP) ? NREQ'(1) << owner : '0;
  assign core_start = state == LAUNCH;
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc ? (byp ? RESP : LAUNCH) : IDLE;
      LAUNCH:  nxt = RUN;
      RUN:     nxt = (cnt == '0) ? RESP : RUN;
      default: nxt = rsp_ready[owner] ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      core_a <= '0;
      core_b <= '0;
      rsp_p <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        core_a <= sa;
        core_b <= sb;
        owner <= g;
        if (byp) rsp_p <= '0;
      end
      if (state == LAUNCH) cnt <= CW'(LAT - 1);
      if (state == RUN) cnt <= cnt - CW'(1);
      if (state == RUN && cnt == '0) rsp_p <= core_p;
      // pointer moves only on a completed response, so every requester gets its turn
      if (state == RESP && rsp_ready[owner]) rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
    end
  end
endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched: randomized and directed checks of booth_mul_sched against a behavioural model
module tb_booth_mul_sched;
  import booth_sched_pkg::*;
  localparam int W = 12;
  localparam int N = 2;
  localparam int LAT = lat_of(W);
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [2*W-1:0] rsp_p, core_p, prod;
  logic core_start, busy;
  logic [W-1:0] core_a, core_b;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ptr = 0;
  int k;
  booth_mul_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_p(core_p), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // core model: product is only correct exactly LAT cycles after the launch pulse
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0;
      prod <= '0;
    end else if (core_start) begin
      k <= 1;
      prod <= (2*W)'(core_a) * (2*W)'(core_b);
    end else if (k != 0 && k < 100) k <= k + 1;
  end
  assign core_p = (k == LAT) ? prod : prod ^ 24'h5A5A5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic op(input logic [N-1:0] mask, input logic [W-1:0] a0, input logic [W-1:0] b0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1, input bit hold, input int stall);
    logic [W-1:0] aa[N];
    logic [W-1:0] bb[N];
    logic [2*W-1:0] e;
    int g, t, n, el;
    aa[0] = a0; bb[0] = b0; aa[1] = a1; bb[1] = b1;
    req_valid = mask;
    req_a = {a1, a0};
    req_b = {b1, b0};
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      check("accept_timeout", 0, 1);
      req_valid = '0;
      return;
    end
    g = pick(mask, ptr);
    check("grant", 32'(req_ready), 32'(1 << g));
    e = (2*W)'(aa[g]) * (2*W)'(bb[g]);
    el = (ZB && (aa[g] == 0 || bb[g] == 0)) ? 1 : 2 + LAT;
    t = cyc;
    @(posedge clk);
    #1;
    if (!hold) req_valid = '0;
    @(negedge clk);
    check("core_start", 32'(core_start), (el == 1) ? 0 : 1);
    check("core_ab", {8'b0, core_a, core_b}, {8'b0, aa[g], bb[g]});
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(cyc - t), 32'(el));
    check("rsp_valid", 32'(rsp_valid), 32'(1 << g));
    check("rsp_p", 32'(rsp_p), 32'(e));
    rsp_ready = ~(N'(1) << g);
    for (int i = 0; i < stall; i++) begin
      req_valid = '1;
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'(1 << g));
      check("stall_p", 32'(rsp_p), 32'(e));
      check("stall_ready", 32'(req_ready), 0);
      check("stall_busy", 32'(busy), 1);
    end
    rsp_ready = N'(1) << g;
    req_valid = hold ? mask : '0;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    ptr = (g + 1) % N;
    @(negedge clk);
    check("idle_after_rsp", 32'(busy), 0);
  endtask

  initial begin
    int t;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_core", {7'b0, core_start, core_a, core_b}, 0);
    check("rst_rsp_p", 32'(rsp_p), 0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    op(2'b01, 12'hABC, 12'h123, 12'h0, 12'h0, 1'b0, 0);
    op(2'b10, 12'h0, 12'h0, 12'hFFF, 12'hFFF, 1'b0, 0);
    for (int i = 0; i < 4; i++) op(2'b11, 12'h800, 12'h002, 12'h001, 12'h7FF, 1'b1, 0);
    req_valid = '0;
    op(2'b11, 12'h0F0, 12'h321, 12'h456, 12'h789, 1'b0, 20);
    op(2'b01, 12'h000, 12'h5A5, 12'h0, 12'h0, 1'b0, 0);
    req_valid = 2'b01;
    req_a = {12'h0, 12'h0AB};
    req_b = {12'h0, 12'h0CD};
    #1;
    check("pre_rst_ready", 32'(req_ready), 1);
    t = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    while (cyc < t + 4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outs", {4'b0, req_ready, rsp_valid, 3'b0, busy, 3'b0, core_start}, 0);
    check("midrst_data", {8'b0, core_a, core_b}, 0);
    check("midrst_p", 32'(rsp_p), 0);
    @(negedge clk);
    rst = 1'b0;
    ptr = 0;
    repeat (15) begin
      @(negedge clk);
      check("no_rsp_after_rst", 32'(rsp_valid), 0);
    end
    op(2'b01, 12'h003, 12'h005, 12'h0, 12'h0, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      ra0 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      rb0 = W'($urandom);
      ra1 = W'($urandom);
      rb1 = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      op(N'($urandom_range(1, 3)), ra0, rb0, ra1, rb1, 1'b0, $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
